tag_lookup_unit: RTL and testbench

Lookup/allocation controller directly upstream of the cache tag memory. Accepts load/store line requests and drives the tag memory's shared read/write port (index, read enable, write enable, write tag). Owns the per-line valid bits, compares the stored tag against the request tag, and reports hit/miss. On a miss it runs a refill handshake with the memory side, then writes the new tag and sets valid.

---
 rtl/tag_lookup_unit_pkg.sv | 53 +++++
 rtl/tag_lookup_unit_valid_bit_array.sv | 48 ++++
 rtl/tag_lookup_unit.sv | 186 ++++++++++++++++++
 tb/tb_tag_lookup_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_lookup_unit_pkg.sv
// -----------------------------------------------------------------------------
// tag_lookup_unit_pkg
//
// Shared cache definitions used by the tag lookup controller, the tag memory
// and the data memory:
//   - default address / index / offset widths for the cache geometry
//   - the lookup FSM state encoding
//   - address-field helpers (get_tag, get_index, line_align)
//
// The helpers work on a 64-bit widened address so they can serve any
// parameterisation up to 64 address bits. Callers widen the address on the
// way in and size-cast the result down to the field width they need.
// -----------------------------------------------------------------------------
package tag_lookup_unit_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH   = 32;
  localparam int unsigned DEFAULT_INDEX_WIDTH  = 8;
  localparam int unsigned DEFAULT_OFFSET_WIDTH = 4;  // 16-byte lines
  localparam int unsigned DEFAULT_TAG_SIZE     =
    DEFAULT_ADDR_WIDTH - DEFAULT_INDEX_WIDTH - DEFAULT_OFFSET_WIDTH;

  typedef logic [63:0] wide_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_ALLOCATE,
    ST_RESPOND
  } lookup_state_e;

  // Tag field: everything above index and offset.
  function automatic wide_addr_t get_tag(input wide_addr_t  addr,
                                         input int unsigned index_width,
                                         input int unsigned offset_width);
    return addr >> (index_width + offset_width);
  endfunction

  // Index field: the index_width bits just above the line offset.
  function automatic wide_addr_t get_index(input wide_addr_t  addr,
                                           input int unsigned index_width,
                                           input int unsigned offset_width);
    return (addr >> offset_width) &
           ((wide_addr_t'(1) << index_width) - wide_addr_t'(1));
  endfunction

  // Line-aligned address: byte offset bits forced to zero.
  function automatic wide_addr_t line_align(input wide_addr_t  addr,
                                            input int unsigned offset_width);
    return addr & ~((wide_addr_t'(1) << offset_width) - wide_addr_t'(1));
  endfunction

endpackage

// File: rtl/tag_lookup_unit_valid_bit_array.sv
// -----------------------------------------------------------------------------
// tag_lookup_unit_valid_bit_array
//
// One valid flop per cache line. Combinational read, single-line set and
// global clear (clear wins over set).
//
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset, clears every line
//   clear_i       invalidate all lines at this edge
//   set_i         mark line set_index_i valid at this edge
//   set_index_i   line to set
//   read_index_i  line to read
//   read_valid_o  valid bit of line read_index_i
// -----------------------------------------------------------------------------
module tag_lookup_unit_valid_bit_array
  import tag_lookup_unit_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   set_i,
  input  logic [INDEX_WIDTH-1:0] set_index_i,
  input  logic [INDEX_WIDTH-1:0] read_index_i,
  output logic                   read_valid_o
);

  localparam int unsigned LINES = 2 ** INDEX_WIDTH;

  logic [LINES-1:0] valid_q;

  // NOTE: unlike the tag RAM this storage must be reset -- every hit is gated
  // by it, which is what makes stale tag RAM contents harmless after reset.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q <= '0;
    end else if (set_i) begin
      valid_q[set_index_i] <= 1'b1;
    end
  end

  assign read_valid_o = valid_q[read_index_i];

endmodule

// File: rtl/tag_lookup_unit.sv
// -----------------------------------------------------------------------------
// tag_lookup_unit
//
// Lookup/allocation controller in front of the cache tag memory. Accepts one
// line request at a time, reads the stored tag, reports hit/miss, and on a
// miss runs a refill handshake before writing the new tag and setting valid.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_address_i request in; req_ready_o high only in IDLE with
//                             no flush
//   rsp_valid_o/rsp_hit_o/    one-cycle response pulse with hit flag and the
//   rsp_address_o             address being answered
//   flush_i                   invalidate all lines (sampled in IDLE only)
//   tag_index_o/tag_read_o/   shared read/write port of the tag memory;
//   tag_write_o/              read data returns the cycle after tag_read_o
//   tag_write_data_o/
//   tag_read_data_i
//   refill_req_o/             line refill request, held until refill_done_i
//   refill_address_o/         pulses; address is line aligned
//   refill_done_i
//
// Flow: IDLE -accept-> LOOKUP -hit-> RESPOND -> IDLE
//                             -miss-> REFILL -done-> ALLOCATE -> RESPOND
// Outputs that are not being driven by the current state are held at 0.
// -----------------------------------------------------------------------------
module tag_lookup_unit
  import tag_lookup_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int unsigned INDEX_WIDTH  = DEFAULT_INDEX_WIDTH,
  parameter int unsigned OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH,
  parameter int unsigned TAG_SIZE     = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  input  logic [ADDR_WIDTH-1:0]  req_address_i,
  output logic                   req_ready_o,
  output logic                   rsp_valid_o,
  output logic                   rsp_hit_o,
  output logic [ADDR_WIDTH-1:0]  rsp_address_o,
  input  logic                   flush_i,
  output logic [INDEX_WIDTH-1:0] tag_index_o,
  output logic                   tag_read_o,
  output logic                   tag_write_o,
  output logic [TAG_SIZE-1:0]    tag_write_data_o,
  input  logic [TAG_SIZE-1:0]    tag_read_data_i,
  output logic                   refill_req_o,
  output logic [ADDR_WIDTH-1:0]  refill_address_o,
  input  logic                   refill_done_i
);

  lookup_state_e          state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;        // request captured on acceptance
  logic                   rsp_hit_q;
  logic                   rsp_valid_q;
  logic                   refill_req_q;
  logic                   tag_write_q;   // high exactly in ALLOCATE

  logic [INDEX_WIDTH-1:0] req_index;
  logic [INDEX_WIDTH-1:0] cap_index;
  logic [TAG_SIZE-1:0]    cap_tag;
  logic [ADDR_WIDTH-1:0]  cap_line;
  logic                   accept;
  logic                   flush_accept;
  logic                   line_valid;
  logic                   lookup_hit;

  // Address fields of the incoming request and of the captured request.
  assign req_index = INDEX_WIDTH'(get_index(wide_addr_t'(req_address_i),
                                            INDEX_WIDTH, OFFSET_WIDTH));
  assign cap_index = INDEX_WIDTH'(get_index(wide_addr_t'(addr_q),
                                            INDEX_WIDTH, OFFSET_WIDTH));
  assign cap_tag   = TAG_SIZE'(get_tag(wide_addr_t'(addr_q),
                                       INDEX_WIDTH, OFFSET_WIDTH));
  assign cap_line  = ADDR_WIDTH'(line_align(wide_addr_t'(addr_q),
                                            OFFSET_WIDTH));

  // Ready is masked during reset so nothing is accepted in the reset cycle.
  assign req_ready_o  = (state_q == ST_IDLE) && !flush_i && !rst_i;
  assign accept       = req_valid_i && req_ready_o;
  assign flush_accept = (state_q == ST_IDLE) && flush_i;

  tag_lookup_unit_valid_bit_array #(
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_valid_bit_array (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (flush_accept),
    .set_i        (tag_write_q),
    .set_index_i  (cap_index),
    .read_index_i (cap_index),
    .read_valid_o (line_valid)
  );

  // Tag RAM contents are only trusted when the line is valid.
  assign lookup_hit = line_valid && (tag_read_data_i == cap_tag);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      refill_req_q <= 1'b0;
      tag_write_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= req_address_i;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          rsp_hit_q <= lookup_hit;
          if (lookup_hit) begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESPOND;
          end else begin
            refill_req_q <= 1'b1;
            state_q      <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (refill_done_i) begin
            refill_req_q <= 1'b0;
            tag_write_q  <= 1'b1;
            state_q      <= ST_ALLOCATE;
          end
        end
        ST_ALLOCATE: begin
          tag_write_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESPOND;
        end
        ST_RESPOND: begin
          rsp_valid_q <= 1'b0;
          rsp_hit_q   <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          rsp_hit_q    <= 1'b0;
          rsp_valid_q  <= 1'b0;
          refill_req_q <= 1'b0;
          tag_write_q  <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: every output gets a default before the conditional overrides, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    tag_index_o      = '0;
    tag_read_o       = accept;
    tag_write_o      = tag_write_q;
    tag_write_data_o = '0;
    refill_req_o     = refill_req_q;
    refill_address_o = '0;
    rsp_valid_o      = rsp_valid_q;
    rsp_hit_o        = 1'b0;
    rsp_address_o    = '0;

    // Accept only happens in IDLE and tag_write_q only in ALLOCATE, so the
    // shared port never sees a read and a write together.
    if (accept) begin
      tag_index_o = req_index;
    end else if (tag_write_q) begin
      tag_index_o      = cap_index;
      tag_write_data_o = cap_tag;
    end

    if (refill_req_q) begin
      refill_address_o = cap_line;
    end

    if (rsp_valid_q) begin
      rsp_hit_o     = rsp_hit_q;
      rsp_address_o = addr_q;
    end
  end

endmodule

// File: tb/tb_tag_lookup_unit.sv
// -----------------------------------------------------------------------------
// tb_tag_lookup_unit
//
// Directed bench for tag_lookup_unit. A small behavioural tag RAM answers the
// shared read/write port one cycle after a read. Inputs change and outputs
// are sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tag_lookup_unit;

  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned INDEX_WIDTH  = 8;
  localparam int unsigned OFFSET_WIDTH = 4;
  localparam int unsigned TAG_SIZE     = 20;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   req_valid_i;
  logic [ADDR_WIDTH-1:0]  req_address_i;
  logic                   req_ready_o;
  logic                   rsp_valid_o;
  logic                   rsp_hit_o;
  logic [ADDR_WIDTH-1:0]  rsp_address_o;
  logic                   flush_i;
  logic [INDEX_WIDTH-1:0] tag_index_o;
  logic                   tag_read_o;
  logic                   tag_write_o;
  logic [TAG_SIZE-1:0]    tag_write_data_o;
  logic [TAG_SIZE-1:0]    tag_read_data_i;
  logic                   refill_req_o;
  logic [ADDR_WIDTH-1:0]  refill_address_o;
  logic                   refill_done_i;

  int n_checks     = 0;
  int n_fails      = 0;
  int n_tag_writes = 0;
  int n_rsps       = 0;
  int n_rw_overlap = 0;

  logic [TAG_SIZE-1:0] tag_mem [2**INDEX_WIDTH];

  tag_lookup_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_address_i    (req_address_i),
    .req_ready_o      (req_ready_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_hit_o        (rsp_hit_o),
    .rsp_address_o    (rsp_address_o),
    .flush_i          (flush_i),
    .tag_index_o      (tag_index_o),
    .tag_read_o       (tag_read_o),
    .tag_write_o      (tag_write_o),
    .tag_write_data_o (tag_write_data_o),
    .tag_read_data_i  (tag_read_data_i),
    .refill_req_o     (refill_req_o),
    .refill_address_o (refill_address_o),
    .refill_done_i    (refill_done_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural tag RAM plus event counters.
  always @(posedge clk_i) begin
    if (tag_read_o) tag_read_data_i <= tag_mem[tag_index_o];
    if (tag_write_o) begin
      tag_mem[tag_index_o] <= tag_write_data_o;
      n_tag_writes++;
    end
    if (rsp_valid_o) n_rsps++;
    if (tag_read_o && tag_write_o) n_rw_overlap++;
  end

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".req_ready"},   64'(req_ready_o),      64'd0);
    check({name, ".rsp_valid"},   64'(rsp_valid_o),      64'd0);
    check({name, ".rsp_hit"},     64'(rsp_hit_o),        64'd0);
    check({name, ".rsp_address"}, 64'(rsp_address_o),    64'd0);
    check({name, ".tag_index"},   64'(tag_index_o),      64'd0);
    check({name, ".tag_read"},    64'(tag_read_o),       64'd0);
    check({name, ".tag_write"},   64'(tag_write_o),      64'd0);
    check({name, ".tag_wdata"},   64'(tag_write_data_o), 64'd0);
    check({name, ".refill_req"},  64'(refill_req_o),     64'd0);
    check({name, ".refill_addr"}, 64'(refill_address_o), 64'd0);
  endtask

  // One complete request with hand-computed expectations. For a miss the
  // refill is held off for wait_cycles before refill_done_i is pulsed.
  task automatic run_req(input string name, input logic [31:0] addr,
                         input bit exp_hit, input logic [31:0] exp_line,
                         input logic [19:0] exp_tag, input logic [7:0] exp_idx,
                         input int wait_cycles);
    @(negedge clk_i);
    req_valid_i   = 1'b1;
    req_address_i = addr;
    #1;
    check({name, ".accept_ready"}, 64'(req_ready_o), 64'd1);
    check({name, ".accept_read"},  64'(tag_read_o),  64'd1);
    check({name, ".accept_index"}, 64'(tag_index_o), 64'(exp_idx));

    @(negedge clk_i);
    req_valid_i   = 1'b0;
    req_address_i = '0;
    #1;
    check({name, ".lookup_ready"}, 64'(req_ready_o), 64'd0);
    check({name, ".lookup_read"},  64'(tag_read_o),  64'd0);

    @(negedge clk_i);
    #1;
    if (exp_hit) begin
      check({name, ".rsp_valid"},  64'(rsp_valid_o),      64'd1);
      check({name, ".rsp_hit"},    64'(rsp_hit_o),        64'd1);
      check({name, ".rsp_addr"},   64'(rsp_address_o),    64'(addr));
      check({name, ".no_refill"},  64'(refill_req_o),     64'd0);
    end else begin
      check({name, ".refill_req"},  64'(refill_req_o),     64'd1);
      check({name, ".refill_addr"}, 64'(refill_address_o), 64'(exp_line));
      check({name, ".no_rsp"},      64'(rsp_valid_o),      64'd0);
      for (int i = 0; i < wait_cycles; i++) begin
        @(negedge clk_i);
        #1;
        check({name, ".hold_req"},   64'(refill_req_o),     64'd1);
        check({name, ".hold_addr"},  64'(refill_address_o), 64'(exp_line));
        check({name, ".hold_ready"}, 64'(req_ready_o),      64'd0);
      end
      refill_done_i = 1'b1;
      @(negedge clk_i);
      refill_done_i = 1'b0;
      #1;
      check({name, ".alloc_write"},  64'(tag_write_o),      64'd1);
      check({name, ".alloc_tag"},    64'(tag_write_data_o), 64'(exp_tag));
      check({name, ".alloc_index"},  64'(tag_index_o),      64'(exp_idx));
      check({name, ".alloc_read"},   64'(tag_read_o),       64'd0);
      check({name, ".alloc_refill"}, 64'(refill_req_o),     64'd0);
      @(negedge clk_i);
      #1;
      check({name, ".rsp_valid"}, 64'(rsp_valid_o),   64'd1);
      check({name, ".rsp_hit"},   64'(rsp_hit_o),     64'd0);
      check({name, ".rsp_addr"},  64'(rsp_address_o), 64'(addr));
      check({name, ".rsp_write"}, 64'(tag_write_o),   64'd0);
    end

    @(negedge clk_i);
    #1;
    check({name, ".done_valid"}, 64'(rsp_valid_o), 64'd0);
    check({name, ".done_ready"}, 64'(req_ready_o), 64'd1);
  endtask

  initial begin : stimulus
    int writes_before;
    int rsps_before;

    // Stale tag RAM that matches line 0x23's first tag and line 0x67's tag:
    // only the valid bits can make these read as misses.
    for (int i = 0; i < 2**INDEX_WIDTH; i++) tag_mem[i] = 20'h00001;
    tag_mem[8'h67]  = 20'h00005;
    tag_read_data_i = '0;

    rst_i         = 1'b1;
    req_valid_i   = 1'b0;
    req_address_i = '0;
    flush_i       = 1'b0;
    refill_done_i = 1'b0;

    // Reset state.
    @(negedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;
    #1;
    check("post_reset_ready", 64'(req_ready_o), 64'd1);

    // Cold miss with 10 cycles of refill backpressure.
    run_req("cold_miss", 32'h0000_1234, 1'b0, 32'h0000_1230, 20'h00001, 8'h23, 10);

    // Hit after fill, different offset in the same line.
    run_req("hit_fill", 32'h0000_1238, 1'b1, 32'h0, 20'h0, 8'h23, 0);

    // refill_done_i pulse while idle is ignored.
    refill_done_i = 1'b1;
    @(negedge clk_i);
    refill_done_i = 1'b0;
    #1;
    check("idle_done.ready",  64'(req_ready_o),  64'd1);
    check("idle_done.refill", 64'(refill_req_o), 64'd0);
    check("idle_done.write",  64'(tag_write_o),  64'd0);
    check("idle_done.rsp",    64'(rsp_valid_o),  64'd0);

    // Conflict: same index, different tag, then the original line misses.
    run_req("conflict_new", 32'h0010_1234, 1'b0, 32'h0010_1230, 20'h00101, 8'h23, 2);
    run_req("conflict_old", 32'h0000_1234, 1'b0, 32'h0000_1230, 20'h00001, 8'h23, 0);
    run_req("conflict_hit", 32'h0000_123C, 1'b1, 32'h0, 20'h0, 8'h23, 0);

    // Flush wins over a simultaneous request.
    @(negedge clk_i);
    flush_i       = 1'b1;
    req_valid_i   = 1'b1;
    req_address_i = 32'h0000_1234;
    #1;
    check("flush.ready", 64'(req_ready_o), 64'd0);
    check("flush.read",  64'(tag_read_o),  64'd0);
    @(negedge clk_i);
    flush_i       = 1'b0;
    req_valid_i   = 1'b0;
    req_address_i = '0;
    #1;
    check("flush.after_read",  64'(tag_read_o),  64'd0);
    check("flush.after_ready", 64'(req_ready_o), 64'd1);
    run_req("post_flush", 32'h0000_1234, 1'b0, 32'h0000_1230, 20'h00001, 8'h23, 1);

    // Reset in the middle of a refill.
    @(negedge clk_i);
    req_valid_i   = 1'b1;
    req_address_i = 32'h0000_5670;
    #1;
    check("abort.accept_index", 64'(tag_index_o), 64'h67);
    @(negedge clk_i);
    req_valid_i   = 1'b0;
    req_address_i = '0;
    @(negedge clk_i);
    #1;
    check("abort.refill_req",  64'(refill_req_o),     64'd1);
    check("abort.refill_addr", 64'(refill_address_o), 64'h0000_5670);
    writes_before = n_tag_writes;
    rsps_before   = n_rsps;
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check_all_zero("abort_reset");
    rst_i = 1'b0;
    #1;
    check("abort.ready_after", 64'(req_ready_o), 64'd1);
    // A late refill_done for the abandoned request must do nothing.
    refill_done_i = 1'b1;
    @(negedge clk_i);
    refill_done_i = 1'b0;
    #1;
    check("abort.late_done_write",  64'(tag_write_o),  64'd0);
    check("abort.late_done_refill", 64'(refill_req_o), 64'd0);
    repeat (3) @(negedge clk_i);
    check("abort.no_write", 64'(n_tag_writes), 64'(writes_before));
    check("abort.no_rsp",   64'(n_rsps),       64'(rsps_before));

    // Previously valid line now misses; aborted line allocates normally.
    run_req("post_reset_miss", 32'h0000_1234, 1'b0, 32'h0000_1230, 20'h00001, 8'h23, 0);
    run_req("abort_line_miss", 32'h0000_5678, 1'b0, 32'h0000_5670, 20'h00005, 8'h67, 1);
    run_req("abort_line_hit",  32'h0000_567C, 1'b1, 32'h0, 20'h0, 8'h67, 0);

    check("no_read_write_overlap", 64'(n_rw_overlap), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
